// File: rtl/sparse_pe_column_v2_if.sv
// Handshake and data bundle for sparse_pe_column_v2.
// The master side is the producer and collector. It drives the job
// (in_valid, in_a, in_b, in_last) and the result acceptance (out_ready).
// The slave side is the PE column. It drives in_ready, the digit progress
// hints (digit_pos, cal_cycle), the results (out_valid, out_result) and the
// sticky per-lane saturation flags (sat_flag).
interface sparse_pe_column_v2_if #(
    parameter int N     = 32,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 26
);
    localparam int D    = A_W / 2;
    localparam int DP_W = $clog2(D);
    localparam int CC_W = DP_W + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [A_W-1:0]       in_a;
    logic [N*B_W-1:0]     in_b;
    logic                 in_last;
    logic [DP_W-1:0]      digit_pos;
    logic [CC_W-1:0]      cal_cycle;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*ACC_W-1:0]   out_result;
    logic [N-1:0]         sat_flag;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, digit_pos, cal_cycle, out_valid, out_result, sat_flag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, digit_pos, cal_cycle, out_valid, out_result, sat_flag
    );
endinterface

// File: rtl/sparse_pe_column_v2.sv
// Sparse PE column: radix-4 Booth recodes multiplicand A and issues only the
// non-zero digits, one per cycle. Each of the N lanes accumulates
// (digit * B_i) << 2*pos into a saturating ACC_W-bit accumulator. A job
// flagged last presents all accumulators through the output handshake.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous abort/clear; wins over every other action
//   bus    slave side of sparse_pe_column_v2_if (job in, results out)
module sparse_pe_column_v2 #(
    parameter int N     = 32,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    sparse_pe_column_v2_if.slave bus
);
    localparam int D    = A_W / 2;
    localparam int DP_W = $clog2(D);
    localparam int CC_W = DP_W + 1;
    localparam logic [D-1:0]             ONE_D   = {{(D-1){1'b0}}, 1'b1};
    localparam logic [CC_W-1:0]          ONE_CC  = {{(CC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Booth digit k from A extended with the implicit a[-1]=0 bit at LSB.
    function automatic logic signed [2:0] booth_digit(input logic [A_W:0] ae,
                                                      input logic [DP_W-1:0] k);
        logic [2:0] grp;
        grp = ae[{k, 1'b0} +: 3];
        case (grp)
            3'b000:  booth_digit = 3'sd0;
            3'b001:  booth_digit = 3'sd1;
            3'b010:  booth_digit = 3'sd1;
            3'b011:  booth_digit = 3'sd2;
            3'b100:  booth_digit = -3'sd2;
            3'b101:  booth_digit = -3'sd1;
            3'b110:  booth_digit = -3'sd1;
            3'b111:  booth_digit = 3'sd0;
            default: booth_digit = 3'sd0;
        endcase
    endfunction

    // One bit per digit position, set where the Booth digit is non-zero.
    function automatic logic [D-1:0] booth_mask(input logic [A_W:0] ae);
        for (int k = 0; k < D; k++) begin
            booth_mask[k] = (booth_digit(ae, DP_W'(k)) != 3'sd0);
        end
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [DP_W-1:0] lowest_set(input logic [D-1:0] m);
        lowest_set = '0;
        for (int k = D - 1; k >= 0; k--) begin
            if (m[k]) begin
                lowest_set = DP_W'(k);
            end
        end
    endfunction

    state_t                   state_r;
    logic [A_W:0]             ae_r;
    logic [N*B_W-1:0]         b_r;
    logic                     last_r;
    logic [D-1:0]             mask_r;
    logic signed [ACC_W-1:0]  acc_r [N];
    logic [N-1:0]             sat_r;
    logic [DP_W-1:0]          digit_pos_r;
    logic [CC_W-1:0]          cal_cycle_r;
    logic                     in_ready_r;
    logic                     out_valid_r;

    logic                     accept_s;
    logic [A_W:0]             in_ae_s;
    logic [D-1:0]             in_mask_s;
    logic [DP_W-1:0]          issue_k_s;
    logic signed [2:0]        issue_d_s;
    logic [D-1:0]             mask_left_s;
    logic signed [ACC_W-1:0]  acc_nxt_s [N];
    logic [N-1:0]             sat_nxt_s;
    logic [N*ACC_W-1:0]       out_result_s;

    // Accept decode and the digit being issued this CALC cycle.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && bus.in_valid && in_ready_r;
        in_ae_s     = {bus.in_a, 1'b0};
        in_mask_s   = booth_mask(in_ae_s);
        issue_k_s   = lowest_set(mask_r);
        issue_d_s   = booth_digit(ae_r, issue_k_s);
        mask_left_s = mask_r & ~(ONE_D << issue_k_s);
    end

    // Per-lane shifted partial product added at ACC_W+1 bits, then clamped.
    always_comb begin
        logic signed [B_W-1:0]  b_s;
        logic signed [B_W+2:0]  prod_s;
        logic signed [ACC_W:0]  term_s;
        logic signed [ACC_W:0]  sum_s;
        sat_nxt_s = '0;
        for (int i = 0; i < N; i++) begin
            b_s    = b_r[i*B_W +: B_W];
            prod_s = (B_W+3)'(issue_d_s) * (B_W+3)'(b_s);
            term_s = (ACC_W+1)'(prod_s) <<< {issue_k_s, 1'b0};
            sum_s  = (ACC_W+1)'(acc_r[i]) + term_s;
            // Top two bits disagree only when the sum left the ACC_W range.
            if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
                acc_nxt_s[i] = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
                sat_nxt_s[i] = 1'b1;
            end else begin
                acc_nxt_s[i] = sum_s[ACC_W-1:0];
                sat_nxt_s[i] = 1'b0;
            end
        end
    end

    // Pack lane accumulators onto the result bus, lane i at slice i.
    always_comb begin
        out_result_s = '0;
        for (int i = 0; i < N; i++) begin
            out_result_s[i*ACC_W +: ACC_W] = acc_r[i];
        end
    end

    // Control FSM together with the lane accumulators and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ae_r        <= '0;
            b_r         <= '0;
            last_r      <= 1'b0;
            mask_r      <= '0;
            sat_r       <= '0;
            digit_pos_r <= '0;
            cal_cycle_r <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_r[i] <= '0;
            end
        end else if (clr) begin
            state_r     <= ST_IDLE;
            mask_r      <= '0;
            sat_r       <= '0;
            digit_pos_r <= '0;
            cal_cycle_r <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ae_r        <= in_ae_s;
                        b_r         <= bus.in_b;
                        last_r      <= bus.in_last;
                        mask_r      <= in_mask_s;
                        // First issued position is known at accept, so the
                        // hint is valid during the first CALC cycle.
                        digit_pos_r <= lowest_set(in_mask_s);
                        cal_cycle_r <= '0;
                        in_ready_r  <= 1'b0;
                        state_r     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < N; i++) begin
                        acc_r[i] <= acc_nxt_s[i];
                    end
                    sat_r  <= sat_r | sat_nxt_s;
                    mask_r <= mask_left_s;
                    // An all-zero A spends one cycle adding zero, not counted.
                    if (mask_r != '0) begin
                        cal_cycle_r <= cal_cycle_r + ONE_CC;
                    end
                    if (mask_left_s != '0) begin
                        digit_pos_r <= lowest_set(mask_left_s);
                    end else if (last_r) begin
                        state_r     <= ST_OUT;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        for (int i = 0; i < N; i++) begin
                            acc_r[i] <= '0;
                        end
                        sat_r       <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_s;
    assign bus.sat_flag   = sat_r;
    assign bus.digit_pos  = digit_pos_r;
    assign bus.cal_cycle  = cal_cycle_r;
endmodule

// File: tb/tb_sparse_pe_column_v2.sv
`timescale 1ns/1ps
module tb_sparse_pe_column_v2;
    localparam int N0   = 32;
    localparam int AW   = 8;
    localparam int BW   = 8;
    localparam int ACC0 = 26;
    localparam int N1   = 4;
    localparam int ACC1 = 16;
    localparam int D    = AW / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr0 = 1'b0;
    logic clr1 = 1'b0;

    always #5 clk = ~clk;

    sparse_pe_column_v2_if #(.N(N0), .A_W(AW), .B_W(BW), .ACC_W(ACC0)) bus0();
    sparse_pe_column_v2_if #(.N(N1), .A_W(AW), .B_W(BW), .ACC_W(ACC1)) bus1();

    sparse_pe_column_v2 #(.N(N0), .A_W(AW), .B_W(BW), .ACC_W(ACC0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .bus(bus0));
    sparse_pe_column_v2 #(.N(N1), .A_W(AW), .B_W(BW), .ACC_W(ACC1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state and lane operands.
    int     b0 [N0];
    int     b1 [N1];
    longint m_acc0 [N0];
    logic   m_sat0 [N0];
    longint m_acc1 [N1];
    logic   m_sat1 [N1];

    // Scoreboards: expected result/sat pushed when a last job is driven.
    logic [N0*ACC0-1:0] exp_res0_q [$];
    logic [N0-1:0]      exp_sat0_q [$];
    logic [N1*ACC1-1:0] exp_res1_q [$];
    logic [N1-1:0]      exp_sat1_q [$];

    function automatic int booth_ref(input logic [AW-1:0] a, input int k);
        logic [AW:0] ae;
        ae = {a, 1'b0};
        return -2 * int'(ae[2*k+2]) + int'(ae[2*k+1]) + int'(ae[2*k]);
    endfunction

    function automatic longint sat_add(input longint acc, input longint add,
                                       input int accw, output logic ovf);
        longint mx, mn, s;
        mx = (longint'(1) <<< (accw - 1)) - 1;
        mn = -(longint'(1) <<< (accw - 1));
        s = acc + add;
        ovf = 1'b0;
        if (s > mx) begin s = mx; ovf = 1'b1; end
        else if (s < mn) begin s = mn; ovf = 1'b1; end
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N0; i++) begin m_acc0[i] = 0; m_sat0[i] = 1'b0; end
        for (int i = 0; i < N1; i++) begin m_acc1[i] = 0; m_sat1[i] = 1'b0; end
    endtask

    task automatic model0(input logic [AW-1:0] a, input logic last);
        logic ovf;
        logic [N0*ACC0-1:0] er;
        logic [N0-1:0] es;
        for (int k = 0; k < D; k++) begin
            int d = booth_ref(a, k);
            if (d != 0) begin
                for (int i = 0; i < N0; i++) begin
                    m_acc0[i] = sat_add(m_acc0[i], longint'(d) * longint'(b0[i]) * (longint'(1) <<< (2*k)), ACC0, ovf);
                    if (ovf) m_sat0[i] = 1'b1;
                end
            end
        end
        if (last) begin
            for (int i = 0; i < N0; i++) begin
                er[i*ACC0 +: ACC0] = ACC0'(m_acc0[i]);
                es[i] = m_sat0[i];
                m_acc0[i] = 0;
                m_sat0[i] = 1'b0;
            end
            exp_res0_q.push_back(er);
            exp_sat0_q.push_back(es);
        end
    endtask

    task automatic model1(input logic [AW-1:0] a, input logic last);
        logic ovf;
        logic [N1*ACC1-1:0] er;
        logic [N1-1:0] es;
        for (int k = 0; k < D; k++) begin
            int d = booth_ref(a, k);
            if (d != 0) begin
                for (int i = 0; i < N1; i++) begin
                    m_acc1[i] = sat_add(m_acc1[i], longint'(d) * longint'(b1[i]) * (longint'(1) <<< (2*k)), ACC1, ovf);
                    if (ovf) m_sat1[i] = 1'b1;
                end
            end
        end
        if (last) begin
            for (int i = 0; i < N1; i++) begin
                er[i*ACC1 +: ACC1] = ACC1'(m_acc1[i]);
                es[i] = m_sat1[i];
                m_acc1[i] = 0;
                m_sat1[i] = 1'b0;
            end
            exp_res1_q.push_back(er);
            exp_sat1_q.push_back(es);
        end
    endtask

    // Present a job to DUT0, wait (bounded) for acceptance; returns just after the accepting edge.
    task automatic send0(input logic [AW-1:0] a, input logic last);
        int w = 0;
        bus0.in_valid = 1'b1;
        bus0.in_a = a;
        bus0.in_last = last;
        for (int i = 0; i < N0; i++) bus0.in_b[i*BW +: BW] = BW'(b0[i]);
        while (bus0.in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        n_checks++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send0_accept: in_ready=%b required 1", bus0.in_ready);
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        model0(a, last);
    endtask

    task automatic send1(input logic [AW-1:0] a, input logic last);
        int w = 0;
        bus1.in_valid = 1'b1;
        bus1.in_a = a;
        bus1.in_last = last;
        for (int i = 0; i < N1; i++) bus1.in_b[i*BW +: BW] = BW'(b1[i]);
        while (bus1.in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        n_checks++;
        if (bus1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send1_accept: in_ready=%b required 1", bus1.in_ready);
        end
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        model1(a, last);
    endtask

    // Wait for DUT0 results, compare with scoreboard, handshake, check clear.
    task automatic recv0(input string tag);
        int c = 0;
        int bad = -1;
        logic [N0*ACC0-1:0] er;
        logic [N0-1:0] es;
        @(negedge clk);
        while (bus0.out_valid !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        n_checks++;
        if (bus0.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_out_timeout: out_valid=%b required 1", tag, bus0.out_valid);
            return;
        end
        n_checks++;
        if (exp_res0_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected_out: out_valid=1 required no output", tag);
            return;
        end
        er = exp_res0_q.pop_front();
        es = exp_sat0_q.pop_front();
        for (int i = N0 - 1; i >= 0; i--)
            if (bus0.out_result[i*ACC0 +: ACC0] !== er[i*ACC0 +: ACC0]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s_result: lane %0d got %h required %h", tag, bad,
                     bus0.out_result[bad*ACC0 +: ACC0], er[bad*ACC0 +: ACC0]);
        end
        n_checks++;
        if (bus0.sat_flag !== es) begin
            n_fail++;
            $display("FAIL %s_sat: got %h required %h", tag, bus0.sat_flag, es);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_result !== '0 || bus0.sat_flag !== '0 || bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_post_handshake: valid=%b ready=%b sat=%h required 0/1/0 with zero result",
                     tag, bus0.out_valid, bus0.in_ready, bus0.sat_flag);
        end
    endtask

    task automatic recv1(input string tag);
        int c = 0;
        logic [N1*ACC1-1:0] er;
        logic [N1-1:0] es;
        @(negedge clk);
        while (bus1.out_valid !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        n_checks++;
        if (bus1.out_valid !== 1'b1 || exp_res1_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_out: out_valid=%b queued=%0d required 1 with an expected entry",
                     tag, bus1.out_valid, exp_res1_q.size());
            return;
        end
        er = exp_res1_q.pop_front();
        es = exp_sat1_q.pop_front();
        n_checks++;
        if (bus1.out_result !== er) begin
            n_fail++;
            $display("FAIL %s_result: got %h required %h", tag, bus1.out_result, er);
        end
        n_checks++;
        if (bus1.sat_flag !== es) begin
            n_fail++;
            $display("FAIL %s_sat: got %b required %b", tag, bus1.sat_flag, es);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus1.out_valid !== 1'b0 || bus1.sat_flag !== '0 || bus1.out_result !== '0) begin
            n_fail++;
            $display("FAIL %s_post_handshake: valid=%b sat=%b required 0 and cleared",
                     tag, bus1.out_valid, bus1.sat_flag);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.digit_pos !== 2'd0 ||
            bus0.cal_cycle !== 3'd0 || bus0.out_result !== '0 || bus0.sat_flag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b pos=%0d cal=%0d required 1/0/0/0",
                     bus0.in_ready, bus0.out_valid, bus0.digit_pos, bus0.cal_cycle);
        end
        // Reset in the middle of a job, after one digit has been accumulated.
        for (int i = 0; i < N0; i++) b0[i] = i;
        send0(8'h7F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b0 || bus0.out_result[5*ACC0 +: ACC0] !== 26'h3FFFFFB) begin
            n_fail++;
            $display("FAIL reset_midcalc_pre: ready=%b lane5=%h required 0/3fffffb",
                     bus0.in_ready, bus0.out_result[5*ACC0 +: ACC0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.digit_pos !== 2'd0 ||
            bus0.cal_cycle !== 3'd0 || bus0.out_result !== '0 || bus0.sat_flag !== '0) begin
            n_fail++;
            $display("FAIL reset_midcalc: ready=%b valid=%b pos=%0d cal=%0d required 1/0/0/0 and zero acc",
                     bus0.in_ready, bus0.out_valid, bus0.digit_pos, bus0.cal_cycle);
        end
    endtask

    task automatic test_two_digits();
        for (int i = 0; i < N0; i++) b0[i] = i;
        send0(8'h7F, 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus0.digit_pos !== 2'd0 || bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL a7f_cycle1: pos=%0d valid=%b ready=%b required 0/0/0",
                     bus0.digit_pos, bus0.out_valid, bus0.in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.digit_pos !== 2'd3 || bus0.out_valid !== 1'b0 || bus0.cal_cycle !== 3'd1) begin
            n_fail++;
            $display("FAIL a7f_cycle2: pos=%0d valid=%b cal=%0d required 3/0/1",
                     bus0.digit_pos, bus0.out_valid, bus0.cal_cycle);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b1 || bus0.cal_cycle !== 3'd2 || bus0.digit_pos !== 2'd3 ||
            bus0.out_result[31*ACC0 +: ACC0] !== 26'd3937) begin
            n_fail++;
            $display("FAIL a7f_latency: valid=%b cal=%0d pos=%0d lane31=%0d required 1/2/3/3937",
                     bus0.out_valid, bus0.cal_cycle, bus0.digit_pos, bus0.out_result[31*ACC0 +: ACC0]);
        end
        recv0("a7f");
    endtask

    task automatic test_single_digit();
        for (int i = 0; i < N0; i++) b0[i] = -1;
        send0(8'h80, 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus0.digit_pos !== 2'd3 || bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a80_cycle1: pos=%0d valid=%b required 3/0", bus0.digit_pos, bus0.out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b1 || bus0.cal_cycle !== 3'd1 || bus0.out_result[0 +: ACC0] !== 26'd128) begin
            n_fail++;
            $display("FAIL a80_latency: valid=%b cal=%0d lane0=%0d required 1/1/128",
                     bus0.out_valid, bus0.cal_cycle, bus0.out_result[0 +: ACC0]);
        end
        recv0("a80");
        // All-zero A: one CALC cycle, adds nothing, no digits counted.
        for (int i = 0; i < N0; i++) b0[i] = i + 1;
        send0(8'h00, 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus0.digit_pos !== 2'd0 || bus0.cal_cycle !== 3'd0 || bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a0_cycle1: pos=%0d cal=%0d valid=%b required 0/0/0",
                     bus0.digit_pos, bus0.cal_cycle, bus0.out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b1 || bus0.cal_cycle !== 3'd0) begin
            n_fail++;
            $display("FAIL a0_latency: valid=%b cal=%0d required 1/0", bus0.out_valid, bus0.cal_cycle);
        end
        recv0("a0");
    endtask

    task automatic test_back_to_back();
        int c = 0;
        for (int i = 0; i < N0; i++) b0[i] = 10;
        send0(8'd3, 1'b0);
        send0(8'd5, 1'b0);
        send0(8'hF9, 1'b1);
        while (bus0.out_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        // Hold out_ready low and require the result to stay put.
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            n_checks++;
            if (bus0.out_valid !== 1'b1 || exp_res0_q.size() == 0 || bus0.out_result !== exp_res0_q[0]) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: valid=%b lane0=%0d required 1/10", h,
                         bus0.out_valid, bus0.out_result[0 +: ACC0]);
            end
        end
        recv0("b2b");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N1; i++) b1[i] = 127;
        send1(8'd127, 1'b0);
        send1(8'd127, 1'b0);
        send1(8'd127, 1'b1);
        n_checks++;
        if (exp_res1_q.size() != 1 || exp_res1_q[0][0 +: ACC1] !== 16'd32767) begin
            n_fail++;
            $display("FAIL sat_model: expected lane0 not 32767");
        end
        recv1("sat");
    endtask

    task automatic test_clr();
        int c = 0;
        for (int i = 0; i < N0; i++) b0[i] = i;
        send0(8'h7F, 1'b1);
        void'(exp_res0_q.pop_back());
        void'(exp_sat0_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_result !== '0 || bus0.in_ready !== 1'b1 ||
            bus0.digit_pos !== 2'd0 || bus0.cal_cycle !== 3'd0) begin
            n_fail++;
            $display("FAIL clr_calc: valid=%b ready=%b pos=%0d cal=%0d required 0/1/0/0 and zero acc",
                     bus0.out_valid, bus0.in_ready, bus0.digit_pos, bus0.cal_cycle);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_result !== '0) begin
            n_fail++;
            $display("FAIL clr_calc_stays_idle: valid=%b required 0", bus0.out_valid);
        end
        send0(8'h7F, 1'b1);
        void'(exp_res0_q.pop_back());
        void'(exp_sat0_q.pop_back());
        while (bus0.out_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        clr0 = 1'b1;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0;
        bus0.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_result !== '0 || bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_out: valid=%b ready=%b required 0/1 and zero acc",
                     bus0.out_valid, bus0.in_ready);
        end
        for (int i = 0; i < N0; i++) b0[i] = 10;
        send0(8'd3, 1'b1);
        recv0("after_clr");
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_last = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
        model_clear();
        test_reset();
        test_two_digits();
        test_single_digit();
        test_back_to_back();
        test_saturation();
        test_clr();
        n_checks++;
        if (exp_res0_q.size() != 0 || exp_res1_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: left %0d/%0d required 0/0", exp_res0_q.size(), exp_res1_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
